// File: rtl/derive_plane_unit.sv
// Plane derivation from a three-point sample: normal = (p1-p0) x (p2-p0), offset = -(normal.p0),
// all products on one time-multiplexed 64x32 signed multiplier. Components pack as {z, y, x}.
module derive_plane_unit #(
    parameter int unsigned MUL_LATENCY = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [95:0]  p0,
    input  logic [95:0]  p1,
    input  logic [95:0]  p2,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [191:0] normal,
    output logic [63:0]  offset,
    output logic         status
);

    localparam logic StatusSuccess       = 1'b0;
    localparam logic StatusLessThanThree = 1'b1;
    localparam int unsigned TagW = 4;

    typedef enum logic [2:0] {StIdle, StEdge, StCross, StDot, StHold} state_e;

    state_e           state_q, state_d;
    logic [2:0][31:0] p0_q, p0_d, p1_q, p1_d, p2_q, p2_d;
    logic [2:0][31:0] v1_q, v1_d, v2_q, v2_d;
    logic [2:0][63:0] nrm_q, nrm_d;
    logic [63:0]      first_q, first_d;
    logic [63:0]      offset_q, offset_d;
    logic [127:0]     acc_q, acc_d;
    logic [2:0]       cnt_q, cnt_d;
    logic             cross_done_q, cross_done_d;
    logic             status_q, status_d;

    logic                   issue_v;
    logic [TagW-1:0]        issue_tag;
    logic [63:0]            mul_a;
    logic [31:0]            mul_b;
    logic signed [95:0]     mul_a_ext, mul_b_ext, mul_p;
    logic [MUL_LATENCY-1:0] mv_q;
    logic [TagW-1:0]        mtag_q  [MUL_LATENCY];
    logic [95:0]            mprod_q [MUL_LATENCY];
    logic                   res_v;
    logic [TagW-1:0]        res_tag;
    logic [95:0]            res_p;
    logic [64:0]            diff;
    logic [127:0]           dot_sum;

    function automatic logic [31:0] sat_single(input logic [32:0] x);
        if (x[32] != x[31]) return x[32] ? 32'h8000_0000 : 32'h7FFF_FFFF;
        return x[31:0];
    endfunction

    function automatic logic [63:0] sat_double(input logic [64:0] x);
        if (x[64] != x[63]) return x[64] ? 64'h8000_0000_0000_0000 : 64'h7FFF_FFFF_FFFF_FFFF;
        return x[63:0];
    endfunction

    // Q48.80 to Q24.40: arithmetic shift right 40, then saturate to 64 bits.
    function automatic logic [63:0] quad_to_double(input logic [127:0] q);
        logic [127:0] s;
        s = $signed(q) >>> 40;
        if (s[127:63] == {65{s[127]}}) return s[63:0];
        return s[127] ? 64'h8000_0000_0000_0000 : 64'h7FFF_FFFF_FFFF_FFFF;
    endfunction

    function automatic logic [63:0] sext64(input logic [31:0] x);
        return {{32{x[31]}}, x};
    endfunction

    // Shared multiplier: slot tags 0-5 are cross products, 6-8 are the offset dot product.
    assign mul_a_ext = {{32{mul_a[63]}}, mul_a};
    assign mul_b_ext = {{64{mul_b[31]}}, mul_b};
    assign mul_p     = mul_a_ext * mul_b_ext;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mv_q <= '0;
        end else begin
            mv_q[0] <= issue_v;
            for (int i = 1; i < int'(MUL_LATENCY); i++) mv_q[i] <= mv_q[i-1];
        end
    end

    always_ff @(posedge clk) begin
        mtag_q[0]  <= issue_tag;
        mprod_q[0] <= mul_p;
        for (int i = 1; i < int'(MUL_LATENCY); i++) begin
            mtag_q[i]  <= mtag_q[i-1];
            mprod_q[i] <= mprod_q[i-1];
        end
    end

    assign res_v   = mv_q[MUL_LATENCY-1];
    assign res_tag = mtag_q[MUL_LATENCY-1];
    assign res_p   = mprod_q[MUL_LATENCY-1];
    assign dot_sum = acc_q + ({{32{res_p[95]}}, res_p} << 20);

    always_comb begin
        issue_v   = 1'b0;
        issue_tag = '0;
        mul_a     = '0;
        mul_b     = '0;
        if (state_q == StCross && cnt_q < 3'd6) begin
            issue_v   = 1'b1;
            issue_tag = {1'b0, cnt_q};
            case (cnt_q)
                3'd0:    begin mul_a = sext64(v1_q[1]); mul_b = v2_q[2]; end
                3'd1:    begin mul_a = sext64(v1_q[2]); mul_b = v2_q[1]; end
                3'd2:    begin mul_a = sext64(v1_q[2]); mul_b = v2_q[0]; end
                3'd3:    begin mul_a = sext64(v1_q[0]); mul_b = v2_q[2]; end
                3'd4:    begin mul_a = sext64(v1_q[0]); mul_b = v2_q[1]; end
                default: begin mul_a = sext64(v1_q[1]); mul_b = v2_q[0]; end
            endcase
        end else if (state_q == StDot && cnt_q < 3'd3) begin
            issue_v   = 1'b1;
            issue_tag = 4'd6 + {1'b0, cnt_q};
            mul_a     = nrm_q[cnt_q[1:0]];
            mul_b     = p0_q[cnt_q[1:0]];
        end
    end

    always_comb begin
        state_d      = state_q;
        p0_d         = p0_q;
        p1_d         = p1_q;
        p2_d         = p2_q;
        v1_d         = v1_q;
        v2_d         = v2_q;
        nrm_d        = nrm_q;
        first_d      = first_q;
        offset_d     = offset_q;
        acc_d        = acc_q;
        cnt_d        = cnt_q;
        cross_done_d = cross_done_q;
        status_d     = status_q;
        diff         = '0;

        // Even cross slots hold the minuend until its partner product arrives.
        if (res_v && res_tag < 4'd6) begin
            if (!res_tag[0]) begin
                first_d = res_p[63:0];
            end else begin
                diff = {first_q[63], first_q} - {res_p[63], res_p[63:0]};
                nrm_d[res_tag[2:1]] = sat_double(diff);
                if (res_tag == 4'd5) cross_done_d = 1'b1;
            end
        end
        if (res_v && res_tag >= 4'd6) acc_d = dot_sum;

        case (state_q)
            StIdle: begin
                if (in_valid) begin
                    p0_d         = p0;
                    p1_d         = p1;
                    p2_d         = p2;
                    cnt_d        = '0;
                    cross_done_d = 1'b0;
                    state_d      = StEdge;
                end
            end
            StEdge: begin
                for (int k = 0; k < 3; k++) begin
                    v1_d[k] = sat_single({p1_q[k][31], p1_q[k]} - {p0_q[k][31], p0_q[k]});
                    v2_d[k] = sat_single({p2_q[k][31], p2_q[k]} - {p0_q[k][31], p0_q[k]});
                end
                state_d = StCross;
            end
            StCross: begin
                if (cnt_q < 3'd6) cnt_d = cnt_q + 3'd1;
                if (cross_done_q) begin
                    cnt_d = '0;
                    acc_d = '0;
                    if (nrm_q == '0) begin
                        status_d = StatusLessThanThree;
                        offset_d = '0;
                        state_d  = StHold;
                    end else begin
                        status_d = StatusSuccess;
                        state_d  = StDot;
                    end
                end
            end
            StDot: begin
                if (cnt_q < 3'd3) cnt_d = cnt_q + 3'd1;
                if (res_v && res_tag == 4'd8) begin
                    offset_d = quad_to_double(-dot_sum);
                    state_d  = StHold;
                end
            end
            StHold: begin
                if (out_ready) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= StIdle;
            p0_q         <= '0;
            p1_q         <= '0;
            p2_q         <= '0;
            v1_q         <= '0;
            v2_q         <= '0;
            nrm_q        <= '0;
            first_q      <= '0;
            offset_q     <= '0;
            acc_q        <= '0;
            cnt_q        <= '0;
            cross_done_q <= 1'b0;
            status_q     <= StatusSuccess;
        end else begin
            state_q      <= state_d;
            p0_q         <= p0_d;
            p1_q         <= p1_d;
            p2_q         <= p2_d;
            v1_q         <= v1_d;
            v2_q         <= v2_d;
            nrm_q        <= nrm_d;
            first_q      <= first_d;
            offset_q     <= offset_d;
            acc_q        <= acc_d;
            cnt_q        <= cnt_d;
            cross_done_q <= cross_done_d;
            status_q     <= status_d;
        end
    end

    assign in_ready  = rst_n && (state_q == StIdle);
    assign out_valid = (state_q == StHold);
    assign normal    = nrm_q;
    assign offset    = offset_q;
    assign status    = status_q;

endmodule

// File: tb/tb_derive_plane_unit.sv
// Randomized self-checking bench for derive_plane_unit against an integer-arithmetic plane model.
module tb_derive_plane_unit;

    localparam int unsigned MulLat = 4;
    localparam logic [31:0] One = 32'h0010_0000;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [95:0]  p0_s = '0, p1_s = '0, p2_s = '0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [191:0] normal;
    logic [63:0]  offset;
    logic         status;

    int n_checks = 0;
    int n_errors = 0;

    derive_plane_unit #(.MUL_LATENCY(MulLat)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .p0       (p0_s),
        .p1       (p1_s),
        .p2       (p2_s),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .normal   (normal),
        .offset   (offset),
        .status   (status)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: got no finish, required finish within 1 ms");
        $fatal(1, "watchdog expired");
    end

    task automatic check_eq(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h required %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [95:0] pt(input logic [31:0] x, input logic [31:0] y,
                                       input logic [31:0] z);
        return {z, y, x};
    endfunction

    function automatic logic signed [127:0] comp(input logic [95:0] p, input int k);
        logic [31:0] c;
        c = p[k*32 +: 32];
        return {{96{c[31]}}, c};
    endfunction

    function automatic logic signed [127:0] clamp(input logic signed [127:0] x, input int bits);
        logic signed [127:0] hi, lo;
        hi = (128'sd1 <<< (bits - 1)) - 128'sd1;
        lo = -hi - 128'sd1;
        if (x > hi) return hi;
        if (x < lo) return lo;
        return x;
    endfunction

    // Plane from the rules: saturated edges, exact cross product clamped to 64 bits,
    // offset = -(n.p0) rescaled from Q.60 to Q.40 with floor and clamp.
    task automatic ref_plane(input logic [95:0] a, input logic [95:0] b, input logic [95:0] c,
                             output logic [191:0] n, output logic [63:0] d, output logic st);
        logic signed [127:0] pa[3], v1[3], v2[3], nn[3], dot, dd;
        for (int k = 0; k < 3; k++) begin
            pa[k] = comp(a, k);
            v1[k] = clamp(comp(b, k) - pa[k], 32);
            v2[k] = clamp(comp(c, k) - pa[k], 32);
        end
        nn[0] = clamp(v1[1] * v2[2] - v1[2] * v2[1], 64);
        nn[1] = clamp(v1[2] * v2[0] - v1[0] * v2[2], 64);
        nn[2] = clamp(v1[0] * v2[1] - v1[1] * v2[0], 64);
        st  = (nn[0] == '0) && (nn[1] == '0) && (nn[2] == '0);
        dot = nn[0] * pa[0] + nn[1] * pa[1] + nn[2] * pa[2];
        dd  = clamp((-dot) >>> 20, 64);
        n   = {nn[2][63:0], nn[1][63:0], nn[0][63:0]};
        d   = st ? 64'h0 : dd[63:0];
    endtask

    // Called at a negedge; returns at the negedge right after the accepting edge.
    task automatic accept_sample(input logic [95:0] a, input logic [95:0] b, input logic [95:0] c,
                                 output int waited);
        p0_s     = a;
        p1_s     = b;
        p2_s     = c;
        in_valid = 1'b1;
        waited   = 0;
        while (!in_ready && waited < 100) begin
            @(negedge clk);
            waited++;
        end
        check_eq("accept_ready", in_ready, 1'b1);
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic wait_result(input string tag, input logic [95:0] a, input logic [95:0] b,
                               input logic [95:0] c);
        logic [191:0] en;
        logic [63:0]  eo;
        logic         es;
        int           n;
        int           exp_lat;
        ref_plane(a, b, c, en, eo, es);
        n = 1;
        while (!out_valid && n < 300) begin
            @(negedge clk);
            n++;
        end
        exp_lat = es ? int'(MulLat) + 9 : 2 * int'(MulLat) + 12;
        check_eq({tag, "_valid"}, out_valid, 1'b1);
        check_eq({tag, "_latency"}, n, exp_lat);
        check_eq({tag, "_normal"}, normal, en);
        check_eq({tag, "_offset"}, offset, eo);
        check_eq({tag, "_status"}, status, es);
    endtask

    task automatic release_result(input string tag);
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        check_eq({tag, "_drop_valid"}, out_valid, 1'b0);
        check_eq({tag, "_idle_ready"}, in_ready, 1'b1);
    endtask

    task automatic run_sample(input string tag, input logic [95:0] a, input logic [95:0] b,
                              input logic [95:0] c);
        int w;
        accept_sample(a, b, c, w);
        wait_result(tag, a, b, c);
        release_result(tag);
    endtask

    function automatic logic [31:0] small_c();
        int s;
        s = int'($urandom_range(0, 16)) - 8;
        return 32'(s * 262144);
    endfunction

    initial begin
        logic [95:0]  a, b, c, d3;
        logic [191:0] hold_n;
        logic [63:0]  hold_o;
        logic         hold_s;
        int           w, mode, stall;

        repeat (2) @(posedge clk);
        @(negedge clk);
        check_eq("rst_in_ready", in_ready, 1'b0);
        check_eq("rst_out_valid", out_valid, 1'b0);
        check_eq("rst_normal", normal, 192'h0);
        check_eq("rst_offset", offset, 64'h0);
        check_eq("rst_status", status, 1'b0);
        rst_n = 1'b1;
        @(negedge clk);
        check_eq("idle_in_ready", in_ready, 1'b1);

        run_sample("basic", pt(0, 0, 0), pt(One, 0, 0), pt(0, One, 0));
        check_eq("basic_const", {normal, offset}, {64'h100_0000_0000, 128'h0, 64'h0});

        accept_sample(pt(0, 0, 5 * One), pt(One, 0, 5 * One), pt(0, One, 5 * One), w);
        wait_result("offset", pt(0, 0, 5 * One), pt(One, 0, 5 * One), pt(0, One, 5 * One));
        check_eq("offset_const", offset, 64'hFFFF_FB00_0000_0000);
        release_result("offset");

        run_sample("coincident", pt(3 * One, 4 * One, 5 * One), pt(3 * One, 4 * One, 5 * One),
                   pt(3 * One, 4 * One, 5 * One));
        run_sample("colinear", pt(0, 0, 0), pt(One, One, One), pt(2 * One, 2 * One, 2 * One));

        accept_sample(pt(32'h8000_0000, 0, 0), pt(32'h7FFF_FFFF, 0, 0), pt(0, One, 0), w);
        wait_result("sat", pt(32'h8000_0000, 0, 0), pt(32'h7FFF_FFFF, 0, 0), pt(0, One, 0));
        check_eq("sat_nz", normal[191:128], 64'h0007_FFFF_FFF0_0000);
        release_result("sat");

        // Backpressure: a second sample waits on in_valid while the result is held.
        a = pt(One, 2 * One, 3 * One);
        b = pt(5 * One, 0, 32'hFFF0_0000);
        c = pt(0, 7 * One, 2 * One);
        accept_sample(pt(0, 0, 5 * One), pt(One, 0, 5 * One), pt(0, One, 5 * One), w);
        wait_result("bp_first", pt(0, 0, 5 * One), pt(One, 0, 5 * One), pt(0, One, 5 * One));
        hold_n = normal;
        hold_o = offset;
        hold_s = status;
        p0_s = a;
        p1_s = b;
        p2_s = c;
        in_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check_eq("bp_normal", normal, hold_n);
            check_eq("bp_rest", {offset, status, out_valid, in_ready}, {hold_o, hold_s, 2'b10});
        end
        release_result("bp_first");
        accept_sample(a, b, c, w);
        check_eq("bp_accept_next", w, 0);
        wait_result("bp_second", a, b, c);
        release_result("bp_second");

        // Abort a sample mid-CROSS; the following sample must be untouched by it.
        accept_sample(pt(32'h0123_4567, 32'h89AB_CDEF, 32'h7654_3210),
                      pt(32'hF00D_0000, 32'h0BAD_F00D, 32'h1234_5678),
                      pt(32'h0000_1111, 32'hDEAD_BEEF, 32'h5555_AAAA), w);
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        check_eq("abort_in_ready", in_ready, 1'b0);
        check_eq("abort_out_valid", out_valid, 1'b0);
        check_eq("abort_normal", normal, 192'h0);
        rst_n = 1'b1;
        @(negedge clk);
        run_sample("after_abort", pt(0, 0, 0), pt(One, 0, 0), pt(0, One, 0));

        for (int it = 0; it < 24; it++) begin
            mode = int'($urandom_range(0, 3));
            for (int k = 0; k < 3; k++) begin
                case (mode)
                    0: begin
                        a[k*32 +: 32] = $urandom;
                        b[k*32 +: 32] = $urandom;
                        c[k*32 +: 32] = $urandom;
                    end
                    1: begin
                        a[k*32 +: 32] = small_c();
                        b[k*32 +: 32] = small_c();
                        c[k*32 +: 32] = small_c();
                    end
                    2: begin
                        a[k*32 +: 32]  = small_c();
                        d3[k*32 +: 32] = small_c();
                        b[k*32 +: 32]  = a[k*32 +: 32] + d3[k*32 +: 32];
                        c[k*32 +: 32]  = a[k*32 +: 32] + 32'd3 * d3[k*32 +: 32];
                    end
                    default: begin
                        a[k*32 +: 32] = $urandom;
                        b[k*32 +: 32] = a[k*32 +: 32];
                        c[k*32 +: 32] = small_c();
                    end
                endcase
            end
            accept_sample(a, b, c, w);
            wait_result("rand", a, b, c);
            hold_n = normal;
            hold_o = offset;
            stall  = int'($urandom_range(0, 3));
            for (int s = 0; s < stall; s++) begin
                @(negedge clk);
                check_eq("rand_hold", {normal, offset}, {hold_n, hold_o});
            end
            release_result("rand");
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/derive_plane_unit.md
# derive_plane_unit

Sequential plane-derivation stage of the RANSAC datapath. Consumes a sample of three `vector::point_t` points from the sampler and produces the plane normal `n = (p1-p0) x (p2-p0)` and offset `d = -(n·p0)`, so that plane points satisfy `n·x + d = 0`. Results are in `vector::double_t` with a `vector::derive_plane_status_e` status and feed the downstream inlier-scoring stage. One shared pipelined multiplier is time-multiplexed across all products.

## Interface
- `MUL_LATENCY`, default `vector::fma_latency_singles` (4): pipeline depth of the shared multiplier, in cycles from issue to registered product; legal values are 1 to 16.
- `clk`  in  1  sole clock; all logic is on the rising edge.
- `rst_n`  in  1  synchronous, active-low reset.
- `in_valid`  in  1  sample presented.
- `in_ready`  out  1  unit idle, sample can be accepted.
- `p0`, `p1`, `p2`  in  `vector::point_t` (96 bits each)  sample points, Q12.20 per component.
- `out_valid`  out  1  result held.
- `out_ready`  in  1  consumer accepts result.
- `normal`  out  `vector::vector3d_s` (192 bits)  plane normal, Q24.40 per component.
- `offset`  out  `vector::double_t` (64 bits)  plane offset, Q24.40.
- `status`  out  `vector::derive_plane_status_e`  `SUCCESS`, or `LESS_THAN_THREE_UNIQUE_POINTS`.

## Operation
- FSM states are IDLE, EDGE, CROSS, DOT, and HOLD.
- **IDLE**
  - `in_ready`=1.
  - On `in_valid && in_ready`, register the points and go to EDGE.
- **EDGE** (1 cycle)
  - Compute `v1=p1-p0` and `v2=p2-p0` per component at 33-bit width.
  - Saturate each component to the `single_t` range: `0x7FFFFFFF` or `0x80000000`.
- **CROSS**
  - Issue 6 products, one per cycle, in the order `v1.y*v2.z, v1.z*v2.y, v1.z*v2.x, v1.x*v2.z, v1.x*v2.y, v1.y*v2.x`.
  - Operands are raw `single_t`. Each product is a raw 64-bit Q24.40 value, i.e. exactly `double_t`.
  - Each normal component is the first product minus the second, computed at 65 bits and saturated to `double_t`.
  - Once all three components are written:
    - all components zero: `status`=`LESS_THAN_THREE_UNIQUE_POINTS`, `normal`=0, `offset`=0, go to HOLD (DOT skipped). Coincident and colinear samples both take this path.
    - otherwise `status`=`SUCCESS`, go to DOT.
- **DOT**
  - Issue `n.x*p0.x`, `n.y*p0.y`, `n.z*p0.z`, one per cycle.
  - Each is a 64x32 signed product giving raw Q.60. Shift it left 20 to `quad_t` Q48.80 and accumulate in `quad_t`. No overflow is possible.
  - After the last product, negate the accumulator, convert with `vector::quad_to_double` semantics (arithmetic shift right 40, saturate), write `offset`, go to HOLD.
- **HOLD**
  - `out_valid`=1; outputs stay stable.
  - On `out_ready`, go to IDLE.
  - `in_ready` stays 0 until IDLE. There is no overlap between samples.
- The multiplier is a single instance of width 64x32 signed. CROSS operands are sign-extended to that width.
- Reset values: `in_ready`=0 while `rst_n`=0; `out_valid`=0, `normal`=0, `offset`=0, `status`=`SUCCESS`, state IDLE.

## Timing
- Let T be the accepting edge.
  - EDGE is active in cycle T+1.
  - CROSS issues in cycles T+2 to T+7; the last product is available at T+7+L, where L=`MUL_LATENCY`.
- Latency from T to the rise of `out_valid`:
  - normal path: 2L+12 cycles (20 for L=4).
  - degenerate path: L+9 cycles (13 for L=4).
- `out_valid` stays high while `out_ready`=0. Outputs update only when the FSM is not in HOLD.
- `out_ready` is sampled only in HOLD. Its value outside HOLD is ignored.
- When `out_valid && out_ready`, the next cycle has `out_valid`=0 and `in_ready`=1. The earliest next accept is 1 cycle after the handoff.
- Reset mid-operation: at the next edge with `rst_n`=0, the FSM returns to IDLE and all reset values apply. In-flight multiplier products are discarded, because a per-slot valid pipe is cleared by reset. No stale product may reach a later sample.

## Test plan
- **Basic plane:** p0=(0,0,0), p1=(1,0,0), p2=(0,1,0), `out_ready`=1 → `normal`=(0,0,`0x10000000000`), `offset`=0, `SUCCESS`, after 20 cycles.
- **Offset plane:** p0=(0,0,5), p1=(1,0,5), p2=(0,1,5) → `normal.z`=1.0, `offset`=-5.0 (`0xFFFFFB0000000000`), `SUCCESS`.
- **Degenerate samples:** p0=p1=p2=(3,4,5) → `LESS_THAN_THREE_UNIQUE_POINTS`, `normal`=0, `offset`=0, after 13 cycles. Repeat with colinear (0,0,0), (1,1,1), (2,2,2) → same result.
- **Saturation:** p0=(-2048,0,0), p1=(2047.99,0,0), p2=(0,1,0) → `v1.x` saturates to `0x7FFFFFFF`; `normal.z` equals the raw value `0x7FFFFFFF*0x00100000`; no wrap.
- **Backpressure:** hold `out_ready`=0 for 10 cycles after `out_valid` → outputs bit-stable, `in_ready`=0, the new sample on `in_valid` is not accepted. It is accepted 1 cycle after `out_ready` pulses.
- **Reset mid-operation:** pulse `rst_n`=0 for 1 cycle during CROSS, then send the basic-plane sample → the first result exactly matches the basic-plane result, with no residue from the aborted sample.
